// File: rtl/rv32_run_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32_run_pkg
// Description : Shared types and constants for the RV32I run controller.
//               Run-state encoding, halt-cause codes and the encodings of
//               the two SYSTEM instructions treated as program end.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32_run_pkg;

    // Run-controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } run_state_e;

    // Halt-cause codes reported on halt_cause
    localparam logic [1:0] HC_NONE   = 2'b00;
    localparam logic [1:0] HC_EBREAK = 2'b01;
    localparam logic [1:0] HC_ECALL  = 2'b10;
    localparam logic [1:0] HC_LOOP   = 2'b11;

    // Full 32-bit encodings of the program-end instructions
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;

endpackage : rv32_run_pkg
`default_nettype wire

// File: rtl/rv32_halt_detect.sv
`default_nettype none
// ============================================================================
// Module      : rv32_halt_detect
// Description : Program-end detector. Flags EBREAK, ECALL or a pc that
//               repeats on HALT_REPEAT consecutive retirements. The halt
//               decision is combinational on the current retirement; the
//               caller registers it.
// Ports       : clk   - clock, rising edge
//               rst   - asynchronous active-low reset
//               clear - synchronous tracker clear (new run)
//               valid - a retirement to evaluate this cycle
//               pc    - pc of the retired instruction
//               instr - encoding of the retired instruction
//               halt  - this retirement ends the program
//               cause - halt-cause code accompanying halt
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_halt_detect
    import rv32_run_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int HALT_REPEAT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            valid,
    input  logic [XLEN-1:0] pc,
    input  logic [31:0]     instr,
    output logic            halt,
    output logic [1:0]      cause
);

    // Wide enough to hold HALT_REPEAT itself, the value stored on a loop halt
    localparam int c_rep_w = $clog2(HALT_REPEAT + 1);
    localparam logic [c_rep_w-1:0] c_rep_one  = c_rep_w'(1);
    localparam logic [c_rep_w-1:0] c_rep_halt = c_rep_w'(HALT_REPEAT);

    logic [XLEN-1:0]    r_prev_pc;
    logic               r_prev_valid;
    logic [c_rep_w-1:0] r_repeat;

    logic               w_same_pc;
    logic [c_rep_w-1:0] w_repeat_inc;

    assign w_same_pc    = r_prev_valid && (pc == r_prev_pc);
    assign w_repeat_inc = r_repeat + c_rep_one;

    // Instruction matches outrank the self-loop check
    always_comb begin
        halt  = 1'b0;
        cause = HC_NONE;
        if (valid) begin
            if (instr == INSTR_EBREAK) begin
                halt  = 1'b1;
                cause = HC_EBREAK;
            end else if (instr == INSTR_ECALL) begin
                halt  = 1'b1;
                cause = HC_ECALL;
            end else if (w_same_pc && (w_repeat_inc == c_rep_halt)) begin
                halt  = 1'b1;
                cause = HC_LOOP;
            end
        end
    end

    // Tracker only moves on retirements; bubbles leave it untouched
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev_pc    <= '0;
            r_prev_valid <= 1'b0;
            r_repeat     <= '0;
        end else if (clear) begin
            r_prev_pc    <= '0;
            r_prev_valid <= 1'b0;
            r_repeat     <= '0;
        end else if (valid) begin
            r_prev_pc    <= pc;
            r_prev_valid <= 1'b1;
            r_repeat     <= w_same_pc ? w_repeat_inc : c_rep_one;
        end
    end

endmodule : rv32_halt_detect
`default_nettype wire

// File: rtl/rv32_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rv32_run_ctrl
// Description : Run controller around an RV32I core. On start it holds the
//               core in reset for RST_CYCLES, lets it run while counting
//               cycles and retirements, and stops on EBREAK, ECALL, a pc
//               self-loop or the MAX_CYCLES budget. All outputs registered.
// Ports       : clk        - clock, rising edge
//               rst        - asynchronous active-low reset
//               start      - single-cycle run request (IDLE/DONE only)
//               core_rst   - active-low reset to the core
//               valid      - core retired an instruction
//               pc         - pc of the retired instruction
//               instr      - encoding of the retired instruction
//               busy       - in RESET or RUN
//               done       - in DONE
//               timeout    - run ended on the cycle budget
//               halt_cause - 00 none, 01 ebreak, 10 ecall, 11 self-loop
//               cycle_cnt  - RUN cycles
//               retire_cnt - retirements during RUN
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_run_ctrl
    import rv32_run_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int CNT_W       = 32,
    parameter int RST_CYCLES  = 2,
    parameter int MAX_CYCLES  = 1024,
    parameter int HALT_REPEAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             core_rst,
    input  logic             valid,
    input  logic [XLEN-1:0]  pc,
    input  logic [31:0]      instr,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam int c_hold_w = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(RST_CYCLES - 1);
    localparam logic [c_hold_w-1:0] c_hold_one  = c_hold_w'(1);
    localparam logic [CNT_W-1:0]    c_cyc_last  = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0]    c_cnt_one   = CNT_W'(1);

    run_state_e          r_state;
    logic [c_hold_w-1:0] r_hold;
    logic                r_core_rst;
    logic                r_busy;
    logic                r_done;
    logic                r_timeout;
    logic [1:0]          r_cause;
    logic [CNT_W-1:0]    r_cycle_cnt;
    logic [CNT_W-1:0]    r_retire_cnt;

    logic                w_in_run;
    logic                w_valid_run;
    logic                w_launch;
    logic                w_halt;
    logic [1:0]          w_cause;

    // Retirements outside RUN come from a core held in reset; ignore them
    assign w_in_run    = (r_state == ST_RUN);
    assign w_valid_run = valid && w_in_run;
    assign w_launch    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    rv32_halt_detect #(
        .XLEN        (XLEN),
        .HALT_REPEAT (HALT_REPEAT)
    ) u_halt_detect (
        .clk   (clk),
        .rst   (rst),
        .clear (w_launch),
        .valid (w_valid_run),
        .pc    (pc),
        .instr (instr),
        .halt  (w_halt),
        .cause (w_cause)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_hold       <= '0;
            r_core_rst   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_cause      <= HC_NONE;
            r_cycle_cnt  <= '0;
            r_retire_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state      <= ST_RESET;
                        r_hold       <= '0;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_timeout    <= 1'b0;
                        r_cause      <= HC_NONE;
                        r_cycle_cnt  <= '0;
                        r_retire_cnt <= '0;
                    end
                end
                ST_RESET: begin
                    if (r_hold == c_hold_last) begin
                        r_state    <= ST_RUN;
                        r_core_rst <= 1'b1;
                    end else begin
                        r_hold <= r_hold + c_hold_one;
                    end
                end
                ST_RUN: begin
                    // The final RUN cycle is counted as well, so a budget
                    // expiry leaves cycle_cnt at exactly MAX_CYCLES
                    r_cycle_cnt <= r_cycle_cnt + c_cnt_one;
                    if (valid) begin
                        r_retire_cnt <= r_retire_cnt + c_cnt_one;
                    end
                    if (w_halt) begin
                        r_state    <= ST_DONE;
                        r_cause    <= w_cause;
                        r_core_rst <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end else if (r_cycle_cnt == c_cyc_last) begin
                        r_state    <= ST_DONE;
                        r_timeout  <= 1'b1;
                        r_core_rst <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign core_rst   = r_core_rst;
    assign busy       = r_busy;
    assign done       = r_done;
    assign timeout    = r_timeout;
    assign halt_cause = r_cause;
    assign cycle_cnt  = r_cycle_cnt;
    assign retire_cnt = r_retire_cnt;

endmodule : rv32_run_ctrl
`default_nettype wire

// File: tb/tb_rv32_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32_run_ctrl
// Description : Scoreboard bench for rv32_run_ctrl. Each run's retirement
//               stream is generated up front, its outcome predicted by a
//               program-level model and queued; a monitor pops and compares
//               whenever done rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32_run_ctrl;

    localparam int          MAXC   = 16;
    localparam int          RSTC   = 2;
    localparam int          HREP   = 4;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] ECALL  = 32'h0000_0073;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [1:0]  halt_cause;
    logic [31:0] cycle_cnt;
    logic [31:0] retire_cnt;

    always #5 clk = ~clk;

    rv32_run_ctrl #(
        .XLEN        (32),
        .CNT_W       (32),
        .RST_CYCLES  (RSTC),
        .MAX_CYCLES  (MAXC),
        .HALT_REPEAT (HREP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .core_rst   (core_rst),
        .valid      (valid),
        .pc         (pc),
        .instr      (instr),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .halt_cause (halt_cause),
        .cycle_cnt  (cycle_cnt),
        .retire_cnt (retire_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int cycles;
        int retires;
        int cause;
        bit tmo;
    } exp_t;

    exp_t        exp_q[$];
    bit          p_v  [MAXC];
    logic [31:0] p_pc [MAXC];
    logic [31:0] p_in [MAXC];

    function automatic logic [31:0] rnd_nop();
        return ($urandom() & 32'hFFFF_FF80) | 32'h0000_0013;
    endfunction

    // Program-level outcome: walk the retirement stream, stop at the first
    // program-end event, otherwise the budget runs out.
    function automatic exp_t model();
        exp_t        e;
        int          run_len;
        logic [31:0] last_pc;
        e.retires = 0;
        run_len   = 0;
        last_pc   = '0;
        for (int c = 0; c < MAXC; c++) begin
            if (p_v[c]) begin
                e.retires++;
                e.cycles = c + 1;
                e.tmo    = 1'b0;
                if (p_in[c] == EBREAK) begin e.cause = 1; return e; end
                if (p_in[c] == ECALL)  begin e.cause = 2; return e; end
                if (run_len > 0 && p_pc[c] == last_pc) run_len++;
                else begin last_pc = p_pc[c]; run_len = 1; end
                if (run_len >= HREP) begin e.cause = 3; return e; end
            end
        end
        e.cycles = MAXC;
        e.cause  = 0;
        e.tmo    = 1'b1;
        return e;
    endfunction

    task automatic build(input int mode);
        for (int c = 0; c < MAXC; c++) begin
            p_v[c]  = 1'b1;
            p_pc[c] = 32'h100 + 32'(4 * c);
            p_in[c] = rnd_nop();
        end
        case (mode)
            0: p_in[9] = EBREAK;                       // 10th retire is ebreak
            1: for (int c = 2; c < 6; c++) p_pc[c] = 32'h40;
            2: begin                                   // three repeats then move on
                for (int c = 0; c < 3; c++) p_pc[c] = 32'h40;
                p_pc[3] = 32'h44;
            end
            3: for (int c = 0; c < MAXC; c++) p_v[c] = 1'($urandom_range(0, 1));
            4: p_in[15] = ECALL;                       // halt on the budget cycle
            6: begin                                   // bubbles inside a loop
                p_pc[0] = 32'h40; p_v[1] = 1'b0; p_pc[2] = 32'h40;
                p_v[3] = 1'b0; p_v[4] = 1'b0; p_pc[5] = 32'h40; p_pc[6] = 32'h40;
            end
            default: begin
                for (int c = 0; c < MAXC; c++) begin
                    p_v[c]  = ($urandom_range(0, 3) != 0);
                    p_pc[c] = 32'h40 + 32'(4 * $urandom_range(0, 2));
                    case ($urandom_range(0, 40))
                        0:       p_in[c] = EBREAK;
                        1:       p_in[c] = ECALL;
                        default: p_in[c] = rnd_nop();
                    endcase
                end
            end
        endcase
    endtask

    // Monitor: compare against the oldest prediction on every rising done
    initial begin
        bit   prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (done === 1'b1 && !prev_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_cycle_cnt",  64'(cycle_cnt),  64'(e.cycles));
                    chk("sb_retire_cnt", 64'(retire_cnt), 64'(e.retires));
                    chk("sb_halt_cause", 64'(halt_cause), 64'(e.cause));
                    chk("sb_timeout",    64'(timeout),    64'(e.tmo));
                    chk("sb_core_rst",   64'(core_rst),   64'd0);
                    chk("sb_busy",       64'(busy),       64'd0);
                end
            end
            prev_done = (done === 1'b1);
        end
    end

    task automatic do_run(input int mode, input int mid_start, input int abort_at);
        exp_t e;
        int   n;
        int   k;
        build(mode);
        e = model();
        if (abort_at < 0) exp_q.push_back(e);

        @(negedge clk);
        start = 1'b1;
        valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("launch_busy",    64'(busy),       64'd1);
        chk("launch_done",    64'(done),       64'd0);
        chk("launch_corerst", 64'(core_rst),   64'd0);
        chk("launch_cycle",   64'(cycle_cnt),  64'd0);
        chk("launch_retire",  64'(retire_cnt), 64'd0);
        chk("launch_cause",   64'(halt_cause), 64'd0);
        chk("launch_timeout", 64'(timeout),    64'd0);

        // Garbage retirements and a stray start while the core is held
        valid = 1'b1;
        instr = EBREAK;
        pc    = $urandom();
        start = 1'b1;
        n = 1;
        for (int i = 0; i < 8 && core_rst !== 1'b1; i++) begin
            @(negedge clk);
            if (core_rst !== 1'b1) n++;
            valid = 1'($urandom_range(0, 1));
            instr = $urandom_range(0, 1) ? ECALL : EBREAK;
            start = 1'($urandom_range(0, 1));
        end
        chk("reset_hold_len", 64'(n),         64'(RSTC));
        chk("run_cycle0",     64'(cycle_cnt), 64'd0);
        chk("run_busy",       64'(busy),      64'd1);

        k = 0;
        while (done !== 1'b1 && core_rst === 1'b1 && k < MAXC + 4) begin
            valid = (k < MAXC) ? p_v[k]  : 1'b0;
            pc    = (k < MAXC) ? p_pc[k] : 32'h0;
            instr = (k < MAXC) ? p_in[k] : 32'h13;
            start = (k == mid_start);
            if (k == abort_at) begin
                #2 rst = 1'b0;
                #1;
                chk("abort_core_rst", 64'(core_rst),   64'd0);
                chk("abort_busy",     64'(busy),       64'd0);
                chk("abort_done",     64'(done),       64'd0);
                chk("abort_cycle",    64'(cycle_cnt),  64'd0);
                chk("abort_retire",   64'(retire_cnt), 64'd0);
                chk("abort_cause",    64'(halt_cause), 64'd0);
                @(negedge clk);
                rst   = 1'b1;
                valid = 1'b0;
                start = 1'b0;
                return;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk("run_ended", 64'(done), 64'd1);

        // DONE must hold everything while the frozen core babbles
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1;
            instr = EBREAK;
            pc    = $urandom();
            @(negedge clk);
        end
        valid = 1'b0;
        chk("hold_cycle",  64'(cycle_cnt),  64'(e.cycles));
        chk("hold_retire", 64'(retire_cnt), 64'(e.retires));
        chk("hold_done",   64'(done),       64'd1);
        chk("hold_corerst",64'(core_rst),   64'd0);
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        valid = 1'b0;
        pc    = '0;
        instr = '0;
        repeat (3) @(negedge clk);
        chk("rst_core_rst", 64'(core_rst),   64'd0);
        chk("rst_busy",     64'(busy),       64'd0);
        chk("rst_done",     64'(done),       64'd0);
        chk("rst_timeout",  64'(timeout),    64'd0);
        chk("rst_cause",    64'(halt_cause), 64'd0);
        chk("rst_cycle",    64'(cycle_cnt),  64'd0);
        chk("rst_retire",   64'(retire_cnt), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        do_run(0, -1, -1);   // ebreak as 10th retire
        do_run(1, -1, -1);   // pc stuck at 0x40
        do_run(2,  5, -1);   // near-loop, timeout, stray start mid-run
        do_run(3, -1, -1);   // random bubbles, timeout
        do_run(4, -1, -1);   // ecall on the budget cycle
        do_run(6, -1, -1);   // loop across bubbles
        do_run(0, -1,  5);   // reset pulled mid-run
        do_run(0,  3, -1);   // clean run after the abort
        for (int r = 0; r < 12; r++) begin
            do_run(5, int'($urandom_range(0, 10)), -1);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_rv32_run_ctrl
`default_nettype wire

// File: doc/rv32_run_ctrl.md
Name: rv32_run_ctrl

Overview:
- Synthesizable run controller wrapped around the RV32I core for simulation and FPGA bring-up.
- Sequences the core's active-low reset on a start pulse and counts cycles and retired instructions.
- Detects program end (EBREAK, ECALL or PC self-loop) and enforces a cycle-budget timeout.
- Replaces fixed-delay reset/finish timing in benches with a parametrised, observable run/halt protocol.

Parameters:
- XLEN, 32, width of the pc input.
- CNT_W, 32, width of the cycle and retire counters.
- RST_CYCLES, 2, number of cycles core_rst is held low after a start; must be >= 1.
- MAX_CYCLES, 1024, RUN-cycle budget before timeout; must be <= 2^CNT_W - 1.
- HALT_REPEAT, 4, consecutive valid cycles with an unchanged pc that count as a self-loop halt; must be >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle run request.
- core_rst  out  1  active-low reset driven to the core.
- valid  in  1  core retired an instruction this cycle.
- pc  in  XLEN  pc of the retired instruction.
- instr  in  32  encoding of the retired instruction.
- busy  out  1  high in RESET or RUN.
- done  out  1  high in DONE.
- timeout  out  1  run ended on the cycle budget.
- halt_cause  out  2  00 none, 01 ebreak, 10 ecall, 11 self-loop.
- cycle_cnt  out  CNT_W  number of RUN cycles.
- retire_cnt  out  CNT_W  number of valid cycles in RUN.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, core_rst=0, busy=0, done=0, timeout=0, halt_cause=00, both counters 0, self-loop tracker cleared.
- States: IDLE, RESET, RUN, DONE.
- IDLE: core_rst=0.
  - start=1 -> RESET. Clear counters, timeout, halt_cause and tracker.
- RESET: core_rst=0 for exactly RST_CYCLES cycles, then -> RUN.
- RUN: core_rst=1.
  - cycle_cnt increments every cycle; retire_cnt increments when valid=1.
- Halt detection, evaluated on valid RUN cycles, priority high to low:
  - instr==0x00100073 -> cause 01.
  - instr==0x00000073 -> cause 10.
  - Self-loop -> cause 11.
  - The halting instruction is counted in retire_cnt.
  - Next edge -> DONE with halt_cause latched.
- Self-loop tracker: holds prev_pc, prev_valid flag and a repeat count.
  - First valid in RUN: load prev_pc, repeat=1.
  - Later valid with pc==prev_pc: repeat+1. Otherwise reload, repeat=1.
  - Halt when repeat would reach HALT_REPEAT.
  - Cycles with valid=0 leave the tracker unchanged.
- Timeout: on the RUN cycle where cycle_cnt==MAX_CYCLES-1, with no halt that cycle:
  - Next edge -> DONE, timeout=1, halt_cause=00, cycle_cnt=MAX_CYCLES.
  - If a halt occurs on the same cycle, the halt wins and timeout=0.
- DONE: core_rst=0 (core frozen), done=1, counters and status hold.
  - start=1 -> RESET with full clear (done drops next cycle).
- start is ignored in RESET and RUN.
- rst asserted mid-operation aborts immediately to the reset values.
- All outputs are registered, with no combinational path from inputs to outputs.

Decomposition:
- Package rv32_run_pkg: state enum; halt-cause codes HC_NONE, HC_EBREAK, HC_ECALL, HC_LOOP; constants INSTR_EBREAK=32'h00100073 and INSTR_ECALL=32'h00000073.
- Sub-module rv32_halt_detect: instruction compare plus self-loop tracker.
  - Inputs: clk, rst, clear, valid, pc, instr.
  - Outputs: halt, cause.
- The top level holds the FSM, reset-hold counter, cycle/retire counters and timeout compare.

Test Plan:
- Release rst after 3 cycles, pulse start -> busy=1 next cycle; core_rst low exactly 2 cycles, then high; cycle_cnt begins at 0.
- RUN with valid=1 each cycle, pc=0,4,8,...; ebreak as the 10th retire -> next cycle done=1, halt_cause=01, retire_cnt=10, core_rst=0.
- pc held at 0x40 with valid=1 for 4 cycles -> done, cause 11. Same pc for 3 cycles then 0x44 -> no halt.
- MAX_CYCLES=16, no halt -> done, timeout=1, cycle_cnt=16. Repeat with ecall on cycle 15 -> cause 10, timeout=0.
- start pulsed mid-RUN -> no effect. rst pulled low mid-RUN -> same cycle core_rst=0, busy=0, counters 0.
- From DONE, pulse start -> done=0, all status cleared, RESET hold repeats, second run counts from 0.
